// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Summary  : Pipeline stall/flush controller with a memory-wait FSM.
//            Define HAZARD_PERF_CNT_EN to build the saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_id_vld,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_rs1_use,
  input  logic        i_id_rs2_use,
  input  logic        i_ex_vld,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_is_load,
  input  logic        i_ex_br_vld,
  input  logic        i_ex_mispred,
  input  logic        i_mem_req,
  input  logic        i_mem_ack,
  output logic        o_pc_en,
  output logic        o_if_id_en,
  output logic        o_id_ex_en,
  output logic        o_ex_mem_en,
  output logic        o_mem_wb_en,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_mem_err,
  output logic [1:0]  o_state,
  output logic [31:0] o_perf_stall,
  output logic [31:0] o_perf_flush,
  output logic [31:0] o_perf_timeout
);

  localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             freeze;
  logic             load_use;
  logic             mispred;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = '0;
        if (i_mem_req && !i_mem_ack) begin
          freeze     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = CNT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        freeze = i_mem_req && !i_mem_ack;
        if (i_mem_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d    = ST_MEM_ERR;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      ST_MEM_ERR: begin
        // Single-cycle abort; the request is ignored so the faulted op retires.
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    load_use = i_id_vld && i_ex_vld && i_ex_is_load && (i_ex_rd != 5'd0) &&
               ((i_id_rs1_use && (i_id_rs1 == i_ex_rd)) ||
                (i_id_rs2_use && (i_id_rs2 == i_ex_rd)));
    mispred  = i_ex_br_vld && i_ex_mispred;
  end

  always_comb begin
    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_id_ex_en    = 1'b1;
    o_ex_mem_en   = 1'b1;
    o_mem_wb_en   = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    if (freeze) begin
      o_pc_en     = 1'b0;
      o_if_id_en  = 1'b0;
      o_id_ex_en  = 1'b0;
      o_ex_mem_en = 1'b0;
      o_mem_wb_en = 1'b0;
    end else if (mispred) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (load_use && (state_q != ST_MEM_ERR)) begin
      // MEM_ERR keeps every stage moving, so a load-use stall waits a cycle.
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
    end
  end

  assign o_state   = state_q;
  assign o_mem_err = (state_q == ST_MEM_ERR);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_timeout_q, perf_timeout_d;

  always_comb begin
    perf_stall_d   = perf_stall_q;
    perf_flush_d   = perf_flush_q;
    perf_timeout_d = perf_timeout_q;
    if (!o_pc_en && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (o_if_id_flush && (perf_flush_q != 32'hFFFF_FFFF)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
    if ((state_d == ST_MEM_ERR) && (state_q != ST_MEM_ERR) &&
        (perf_timeout_q != 32'hFFFF_FFFF)) begin
      perf_timeout_d = perf_timeout_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
      perf_timeout_q <= '0;
    end else begin
      perf_stall_q   <= perf_stall_d;
      perf_flush_q   <= perf_flush_d;
      perf_timeout_q <= perf_timeout_d;
    end
  end

  assign o_perf_stall   = perf_stall_q;
  assign o_perf_flush   = perf_flush_q;
  assign o_perf_timeout = perf_timeout_q;
`else
  assign o_perf_stall   = 32'd0;
  assign o_perf_flush   = 32'd0;
  assign o_perf_timeout = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Summary  : Vector table plus multi-cycle sequences for hazard_ctrl (MEM_TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  typedef struct {
    logic       id_vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_use;
    logic       rs2_use;
    logic       ex_vld;
    logic [4:0] rd;
    logic       is_load;
    logic       br_vld;
    logic       mispred;
    logic       req;
    logic       ack;
    logic [4:0] en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0] fl;   // {if_id_flush, id_ex_flush}
    logic [1:0] st;
    logic       err;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_id_vld, i_id_rs1_use, i_id_rs2_use, i_ex_vld, i_ex_is_load;
  logic        i_ex_br_vld, i_ex_mispred, i_mem_req, i_mem_ack;
  logic [4:0]  i_id_rs1, i_id_rs2, i_ex_rd;
  logic        o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
  logic        o_if_id_flush, o_id_ex_flush, o_mem_err;
  logic [1:0]  o_state;
  logic [31:0] o_perf_stall, o_perf_flush, o_perf_timeout;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          tag      = 0;
  int          exp_stall = 0, exp_flush = 0, exp_timeout = 0;
  vec_t        sb[$];
  vec_t        tbl[12];
  vec_t        idle, req_only, req_ack;

  always #5 i_clk = ~i_clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_id_vld(i_id_vld), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_rs1_use(i_id_rs1_use), .i_id_rs2_use(i_id_rs2_use),
    .i_ex_vld(i_ex_vld), .i_ex_rd(i_ex_rd), .i_ex_is_load(i_ex_is_load),
    .i_ex_br_vld(i_ex_br_vld), .i_ex_mispred(i_ex_mispred),
    .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_id_ex_en(o_id_ex_en),
    .o_ex_mem_en(o_ex_mem_en), .o_mem_wb_en(o_mem_wb_en),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_mem_err(o_mem_err), .o_state(o_state),
    .o_perf_stall(o_perf_stall), .o_perf_flush(o_perf_flush),
    .o_perf_timeout(o_perf_timeout)
  );

  function automatic vec_t mk(input logic id_vld, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic rs1_use, input logic rs2_use, input logic ex_vld,
                              input logic [4:0] rd, input logic is_load, input logic br_vld,
                              input logic mispred, input logic req, input logic ack,
                              input logic [4:0] en, input logic [1:0] fl,
                              input logic [1:0] st, input logic err);
    vec_t v;
    v.id_vld = id_vld; v.rs1 = rs1; v.rs2 = rs2; v.rs1_use = rs1_use; v.rs2_use = rs2_use;
    v.ex_vld = ex_vld; v.rd = rd; v.is_load = is_load; v.br_vld = br_vld; v.mispred = mispred;
    v.req = req; v.ack = ack; v.en = en; v.fl = fl; v.st = st; v.err = err;
    return v;
  endfunction

  function automatic vec_t with_exp(input vec_t b, input logic [4:0] en, input logic [1:0] fl,
                                    input logic [1:0] st, input logic err);
    vec_t v;
    v = b; v.en = en; v.fl = fl; v.st = st; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, t, act, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int val);
`ifdef HAZARD_PERF_CNT_EN
    return 32'(val);
`else
    return (val == val) ? 32'd0 : 32'd1;
`endif
  endfunction

  task automatic apply(input vec_t v);
    i_id_vld = v.id_vld; i_id_rs1 = v.rs1; i_id_rs2 = v.rs2;
    i_id_rs1_use = v.rs1_use; i_id_rs2_use = v.rs2_use;
    i_ex_vld = v.ex_vld; i_ex_rd = v.rd; i_ex_is_load = v.is_load;
    i_ex_br_vld = v.br_vld; i_ex_mispred = v.mispred;
    i_mem_req = v.req; i_mem_ack = v.ack;
  endtask

  task automatic compare(input vec_t v);
    if (v.st == 2'd2) exp_timeout++;
    chk("enables", tag, {27'd0, o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en},
        {27'd0, v.en});
    chk("flushes", tag, {30'd0, o_if_id_flush, o_id_ex_flush}, {30'd0, v.fl});
    chk("state", tag, {30'd0, o_state}, {30'd0, v.st});
    chk("mem_err", tag, {31'd0, o_mem_err}, {31'd0, v.err});
    chk("perf_stall", tag, o_perf_stall, perf_exp(exp_stall));
    chk("perf_flush", tag, o_perf_flush, perf_exp(exp_flush));
    chk("perf_timeout", tag, o_perf_timeout, perf_exp(exp_timeout));
    if (!v.en[4]) exp_stall++;
    if (v.fl[1]) exp_flush++;
  endtask

  task automatic step(input vec_t v);
    @(posedge i_clk);
    #1;
    apply(v);
    sb.push_back(v);
    @(negedge i_clk);
    tag++;
    compare(sb.pop_front());
  endtask

  initial begin
    idle     = mk(0,0,0,0,0,0,0,0,0,0,0,0, 5'b11111, 2'b00, 2'd0, 0);
    req_only = mk(0,0,0,0,0,0,0,0,0,0,1,0, 5'b00000, 2'b00, 2'd0, 0);
    req_ack  = mk(0,0,0,0,0,0,0,0,0,0,1,1, 5'b11111, 2'b00, 2'd0, 0);

    //           idv rs1 rs2 u1 u2 exv rd ld br mp rq ak  en        fl     st err
    tbl[0]  = mk(0,  0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0);
    tbl[1]  = mk(1,  5,  1,  1, 1, 1,  5, 1, 0, 0, 0, 0, 5'b00111, 2'b01, 0, 0);
    tbl[2]  = mk(1,  6,  1,  1, 1, 1,  6, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0);
    tbl[3]  = mk(1,  0,  1,  1, 1, 1,  0, 1, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0);
    tbl[4]  = mk(1,  3,  7,  1, 1, 1,  7, 1, 0, 0, 0, 0, 5'b00111, 2'b01, 0, 0);
    tbl[5]  = mk(1,  3,  7,  1, 0, 1,  7, 1, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0);
    tbl[6]  = mk(0,  5,  1,  1, 1, 1,  5, 1, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0);
    tbl[7]  = mk(1,  5,  1,  1, 1, 0,  5, 1, 0, 0, 0, 0, 5'b11111, 2'b00, 0, 0);
    tbl[8]  = mk(1,  5,  1,  1, 1, 1,  5, 1, 1, 1, 0, 0, 5'b11111, 2'b11, 0, 0);
    tbl[9]  = mk(0,  0,  0,  0, 0, 1,  9, 0, 1, 0, 0, 0, 5'b11111, 2'b00, 0, 0);
    tbl[10] = mk(0,  0,  0,  0, 0, 1,  9, 0, 0, 1, 0, 0, 5'b11111, 2'b00, 0, 0);
    tbl[11] = mk(0,  0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 1, 5'b11111, 2'b00, 0, 0);

    apply(idle);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("reset_enables", 0, {27'd0, o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en},
        32'h1F);
    chk("reset_flushes", 0, {30'd0, o_if_id_flush, o_id_ex_flush}, 32'd0);
    chk("reset_state", 0, {30'd0, o_state}, 32'd0);
    chk("reset_mem_err", 0, {31'd0, o_mem_err}, 32'd0);
    chk("reset_perf", 0, o_perf_stall | o_perf_flush | o_perf_timeout, 32'd0);
    i_reset = 1'b1;

    for (int i = 0; i < 12; i++) step(tbl[i]);

    // Request held three cycles, ack on the third: two frozen cycles.
    step(with_exp(req_only, 5'b00000, 2'b00, 2'd0, 0));
    step(with_exp(req_only, 5'b00000, 2'b00, 2'd1, 0));
    step(with_exp(req_ack,  5'b11111, 2'b00, 2'd1, 0));
    step(idle);

    // No ack: four frozen cycles, then a single MEM_ERR cycle with the request ignored.
    step(with_exp(req_only, 5'b00000, 2'b00, 2'd0, 0));
    step(with_exp(req_only, 5'b00000, 2'b00, 2'd1, 0));
    step(with_exp(req_only, 5'b00000, 2'b00, 2'd1, 0));
    step(with_exp(req_only, 5'b00000, 2'b00, 2'd1, 0));
    step(with_exp(req_only, 5'b11111, 2'b00, 2'd2, 1));
    step(idle);
    step(idle);

    // Mispredict held through a wait: flush only in the ack cycle.
    step(with_exp(req_only, 5'b00000, 2'b00, 2'd0, 0));
    step(mk(0,0,0,0,0,1,3,0,1,1,1,0, 5'b00000, 2'b00, 2'd1, 0));
    step(mk(0,0,0,0,0,1,3,0,1,1,1,1, 5'b11111, 2'b11, 2'd1, 0));
    step(idle);

    // Asynchronous reset in the second MEM_WAIT cycle.
    step(with_exp(req_only, 5'b00000, 2'b00, 2'd0, 0));
    step(with_exp(req_only, 5'b00000, 2'b00, 2'd1, 0));
    @(posedge i_clk);
    #1;
    chk("wait_state_before_reset", tag, {30'd0, o_state}, 32'd1);
    #2;
    i_reset = 1'b0;
    apply(idle);
    #1;
    chk("async_reset_state", tag, {30'd0, o_state}, 32'd0);
    chk("async_reset_enables", tag,
        {27'd0, o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en}, 32'h1F);
    chk("async_reset_mem_err", tag, {31'd0, o_mem_err}, 32'd0);
    chk("async_reset_perf", tag, o_perf_stall | o_perf_flush | o_perf_timeout, 32'd0);
    exp_stall = 0; exp_flush = 0; exp_timeout = 0;
    @(negedge i_clk);
    i_reset = 1'b1;
    step(idle);
    step(idle);
    step(idle);
    step(idle);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
